// File: rtl/gcd_engine_if.sv
// Operand/result handshake bundle for gcd_engine; master drives operands and out_ready.
// Purely structural: no latency, flow control is plain valid/ready on both sides.
interface gcd_engine_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic             zero_err;
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, gcd_out, zero_err, iter_cnt
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, gcd_out, zero_err, iter_cnt
    );
endinterface

// File: rtl/gcd_engine.sv
// GCD engine: subtractive Euclid, or binary Stein when GCD_STEIN_EN is defined.
// Latency: iter_cnt+1 cycles from accept to out_valid (zero operand: DONE on the accept edge).
// Backpressure: accepts only in IDLE, holds the result in DONE until out_ready.
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    gcd_engine_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] gcd_q;
    logic             zero_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_sat;

`ifdef GCD_STEIN_EN
    localparam int K_W = $clog2(WIDTH) + 1;
    logic [K_W-1:0] k_q;
`endif

    assign cnt_sat = &cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            gcd_q  <= '0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
`ifdef GCD_STEIN_EN
            k_q    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a_in;
                        b_q   <= bus.b_in;
                        cnt_q <= '0;
`ifdef GCD_STEIN_EN
                        k_q   <= '0;
`endif
                        // A zero operand needs no iteration: gcd(x,0) = x.
                        if (bus.a_in == '0 || bus.b_in == '0) begin
                            gcd_q  <= bus.a_in | bus.b_in;
                            zero_q <= (bus.a_in == '0) && (bus.b_in == '0);
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                        end
                    end
                end

                S_CALC: begin
`ifdef GCD_STEIN_EN
                    if (a_q == b_q) begin
                        gcd_q  <= a_q << k_q;
                        zero_q <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        if (!a_q[0] && !b_q[0]) begin
                            a_q <= a_q >> 1;
                            b_q <= b_q >> 1;
                            k_q <= k_q + 1'b1;
                        end else if (!a_q[0]) begin
                            a_q <= a_q >> 1;
                        end else if (!b_q[0]) begin
                            b_q <= b_q >> 1;
                        end else if (a_q > b_q) begin
                            a_q <= a_q - b_q;
                        end else begin
                            b_q <= b_q - a_q;
                        end
                        if (!cnt_sat) cnt_q <= cnt_q + 1'b1;
                    end
`else
                    if (a_q == b_q) begin
                        gcd_q  <= a_q;
                        zero_q <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        // Always larger minus smaller, so no underflow.
                        if (a_q > b_q) a_q <= a_q - b_q;
                        else           b_q <= b_q - a_q;
                        if (!cnt_sat) cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.gcd_out   = gcd_q;
    assign bus.zero_err  = zero_q;
    assign bus.iter_cnt  = cnt_q;

    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state != 2'd3);

    a_result_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_DONE && !bus.out_ready) |=>
            (state == S_DONE && $stable(gcd_q) && $stable(zero_q) && $stable(cnt_q)));

    a_calc_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_CALC) |-> (a_q != '0 && b_q != '0));
endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboarded bench for gcd_engine: expected results queued at stimulus, checked on output handshake.
module tb_gcd_engine;
    typedef struct packed {
        logic [15:0] gcd;
        logic        zero;
        logic [15:0] iter;
    } exp_t;

    logic clk;
    logic rst_n;
    gcd_engine_if #(.WIDTH(16), .CNT_W(16)) bus ();

    gcd_engine #(.WIDTH(16), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks  = 0;
    int   errors  = 0;
    int   out_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // gcd by remainder Euclid; iteration count follows the subtractive step count
    function automatic void model(input logic [15:0] a, input logic [15:0] b, output exp_t e);
        logic [15:0] x, y, t;
        e.zero = (a == 16'd0) && (b == 16'd0);
        e.iter = 16'd0;
        if (a == 16'd0 || b == 16'd0) begin
            e.gcd = a | b;
            return;
        end
        x = a; y = b;
        while (y != 16'd0) begin
            t = x % y; x = y; y = t;
        end
        e.gcd = x;
        x = a; y = b;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
            if (e.iter != 16'hFFFF) e.iter = e.iter + 16'd1;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected_output gcd_out=%0d (no result expected)", bus.gcd_out);
            end else begin
                mon_e = sb.pop_front();
                out_cnt++;
                checks++;
                if (bus.gcd_out !== mon_e.gcd) begin
                    errors++;
                    $display("FAIL sb_gcd got=%0d exp=%0d", bus.gcd_out, mon_e.gcd);
                end
                checks++;
                if (bus.zero_err !== mon_e.zero) begin
                    errors++;
                    $display("FAIL sb_zero_err got=%0b exp=%0b", bus.zero_err, mon_e.zero);
                end
`ifndef GCD_STEIN_EN
                checks++;
                if (bus.iter_cnt !== mon_e.iter) begin
                    errors++;
                    $display("FAIL sb_iter_cnt got=%0d exp=%0d", bus.iter_cnt, mon_e.iter);
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit hold);
        exp_t e;
        int   n;
        model(a, b, e);
        sb.push_back(e);
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL accept_timeout in_ready=%0b exp=1", bus.in_ready);
        end
        tick();
        if (!hold) bus.in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen (0: DONE entered on the accept edge).
    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 70000) begin
            tick();
            lat++;
        end
        if (bus.out_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL out_valid_timeout out_valid=%0b exp=1", bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.out_ready = 1'b1;
        #12;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.gcd_out !== 16'd0) begin errors++; $display("FAIL rst_gcd_out got=%0d exp=0", bus.gcd_out); end
        checks++; if (bus.zero_err !== 1'b0) begin errors++; $display("FAIL rst_zero_err got=%0b exp=0", bus.zero_err); end
        checks++; if (bus.iter_cnt !== 16'd0) begin errors++; $display("FAIL rst_iter_cnt got=%0d exp=0", bus.iter_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        bus.out_ready = 1'b1;
        send(16'd143, 16'd78, 1'b0);
        wait_out(lat);
`ifndef GCD_STEIN_EN
        checks++; if (lat != 7) begin errors++; $display("FAIL basic_latency got=%0d exp=7", lat); end
`endif
        checks++; if (bus.gcd_out !== 16'd13) begin errors++; $display("FAIL basic_gcd got=%0d exp=13", bus.gcd_out); end
        tick();
    endtask

    task automatic test_zero_operands();
        int lat;
        send(16'd0, 16'd0, 1'b0);
        wait_out(lat);
        checks++; if (lat != 0) begin errors++; $display("FAIL zero_both_latency got=%0d exp=0", lat); end
        tick();
        send(16'd0, 16'd25, 1'b0);
        wait_out(lat);
        checks++; if (lat != 0) begin errors++; $display("FAIL zero_a_latency got=%0d exp=0", lat); end
        tick();
        send(16'd7, 16'd0, 1'b0);
        wait_out(lat);
        tick();
    endtask

    task automatic test_equal_and_worst();
        int lat;
        send(16'd40, 16'd40, 1'b0);
        wait_out(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL equal_latency got=%0d exp=1", lat); end
        tick();
        send(16'd65535, 16'd1, 1'b0);
        wait_out(lat);
`ifdef GCD_STEIN_EN
        checks++; if (lat > 33) begin errors++; $display("FAIL worst_latency got=%0d exp<=33", lat); end
`else
        checks++; if (lat != 65535) begin errors++; $display("FAIL worst_latency got=%0d exp=65535", lat); end
`endif
        tick();
    endtask

    task automatic test_hold();
        int   lat;
        exp_t e;
        model(16'd48, 16'd36, e);
        bus.out_ready = 1'b0;
        send(16'd48, 16'd36, 1'b0);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid cyc=%0d got=%0b exp=1", i, bus.out_valid); end
            checks++; if (bus.gcd_out !== e.gcd) begin errors++; $display("FAIL hold_gcd cyc=%0d got=%0d exp=%0d", i, bus.gcd_out, e.gcd); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%0b exp=0", i, bus.in_ready); end
            bus.in_valid = (i % 2 == 0);
            bus.a_in     = 16'd99 + 16'(i);
            bus.b_in     = 16'd33;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got=%0b exp=0", bus.out_valid); end
        repeat (3) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ignored_op_out_valid got=%0b exp=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        bus.out_ready = 1'b1;
        send(16'd1000, 16'd3, 1'b0);
        repeat (20) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midcalc_busy got=%0b exp=0", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.iter_cnt !== 16'd0) begin errors++; $display("FAIL midrst_iter_cnt got=%0d exp=0", bus.iter_cnt); end
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send(16'd12, 16'd18, 1'b0);
        wait_out(lat);
        checks++; if (bus.gcd_out !== 16'd6) begin errors++; $display("FAIL post_rst_gcd got=%0d exp=6", bus.gcd_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa[4];
        logic [15:0] pb[4];
        int          start;
        pa[0] = 16'd270;  pb[0] = 16'd192;
        pa[1] = 16'd17;   pb[1] = 16'd5;
        pa[2] = 16'd0;    pb[2] = 16'd9;
        pa[3] = 16'd1024; pb[3] = 16'd48;
        start = out_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send(pa[i], pb[i], 1'b1);
                bus.in_valid = 1'b0;
            end
            begin
                int n = 0;
                while (out_cnt < start + 4 && n < 5000) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    tick();
                    n++;
                end
            end
        join
        bus.out_ready = 1'b1;
        tick();
        checks++; if (out_cnt - start != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", out_cnt - start); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_pending got=%0d exp=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_operands();
        test_equal_and_worst();
        test_hold();
        test_reset_mid_calc();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
